// File: rtl/lock_monitor_seq.sv
// rtl/lock_monitor_seq.sv - lock/unlock sequence monitor with fault capture; optional hold timeout under LOCKS_HOLD_TIMEOUT_EN
module lock_monitor_seq #(
    parameter int NLOCKS   = 4,
    parameter int CNTW     = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     cmd_valid,
    input  logic [2*NLOCKS-1:0]                      cmd,
    input  logic                                     clear,
    output logic [NLOCKS-1:0]                        locks,
    output logic                                     fault,
    output logic [1:0]                               fault_code,
    output logic [((NLOCKS > 1) ? $clog2(NLOCKS) : 1)-1:0] fault_idx,
    output logic [CNTW-1:0]                          fault_cnt
);

    localparam int IW = (NLOCKS > 1) ? $clog2(NLOCKS) : 1;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    localparam logic [1:0] CODE_SEQ = 2'b01;
    localparam logic [1:0] CODE_TMO = 2'b10;

    logic [0:0]        state;
    logic              in_run;
    logic [NLOCKS-1:0] skip;
    logic [NLOCKS-1:0] op;
    logic [NLOCKS-1:0] viol;
    logic [NLOCKS-1:0] locks_upd;
    logic [NLOCKS-1:0] locks_nxt;
    logic [NLOCKS-1:0] tmo;
    logic [IW-1:0]     viol_idx;
    logic [IW-1:0]     tmo_idx;
    logic              viol_any;
    logic              tmo_any;

    assign in_run = (state == ST_RUN);
    assign fault  = (state == ST_FAULT);

    // Decode per-lock command fields and flag double lock / double unlock
    always_comb begin
        skip      = '0;
        op        = '0;
        viol      = '0;
        locks_upd = locks;
        for (int i = 0; i < NLOCKS; i++) begin
            skip[i] = cmd[2*i+1];
            op[i]   = cmd[2*i];
            viol[i] = in_run && cmd_valid && !skip[i] && (op[i] == locks[i]);
            if (!skip[i]) begin
                locks_upd[i] = op[i];
            end
        end
    end

`ifdef LOCKS_HOLD_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_cnt [NLOCKS];

    // A held lock at its last allowed cycle times out unless this cycle's accepted cmd unlocks it
    always_comb begin
        tmo = '0;
        for (int i = 0; i < NLOCKS; i++) begin
            tmo[i] = in_run && locks[i] && (hold_cnt[i] == HOLD_LAST) &&
                     !(cmd_valid && !skip[i] && !op[i]);
        end
    end

    // Hold counters advance on held RUN cycles, clear on unlock, freeze in FAULT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NLOCKS; i++) begin
                hold_cnt[i] <= '0;
            end
        end else if (in_run) begin
            for (int i = 0; i < NLOCKS; i++) begin
                if (!locks_nxt[i]) begin
                    hold_cnt[i] <= '0;
                end else if (locks[i] && (hold_cnt[i] != HOLD_LAST)) begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign tmo = '0;
`endif

    // Lowest offending index for each fault source
    always_comb begin
        viol_idx = '0;
        tmo_idx  = '0;
        for (int i = NLOCKS - 1; i >= 0; i--) begin
            if (viol[i]) begin
                viol_idx = IW'(i);
            end
            if (tmo[i]) begin
                tmo_idx = IW'(i);
            end
        end
    end

    assign viol_any = |viol;
    assign tmo_any  = |tmo;

    // Any fault freezes the lock state; otherwise apply accepted commands
    always_comb begin
        locks_nxt = locks;
        if (in_run && cmd_valid && !viol_any && !tmo_any) begin
            locks_nxt = locks_upd;
        end
    end

    // State, lock register and fault capture; a bad sequence outranks a timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            locks      <= '0;
            fault_code <= 2'b00;
            fault_idx  <= '0;
            fault_cnt  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    locks <= locks_nxt;
                    if (viol_any || tmo_any) begin
                        state      <= ST_FAULT;
                        fault_code <= viol_any ? CODE_SEQ : CODE_TMO;
                        fault_idx  <= viol_any ? viol_idx : tmo_idx;
                        if (fault_cnt != {CNTW{1'b1}}) begin
                            fault_cnt <= fault_cnt + 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    if (clear) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule
